// File: rtl/softmax_ctrl_if.sv
// Host-facing command/row-source handshake plus the softmax core pin bundle.
// The slave modport is the controller; the master modport is the host/core side.
interface softmax_ctrl_if #(
  parameter int BW  = 8,
  parameter int COL = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic                abort;
  logic                src_valid;
  logic                src_ready;
  logic [COL*BW-1:0]   src_data;
  logic [COL*BW-1:0]   sm_in;
  logic [1:0]          sm_lut_wr;
  logic                sm_execute;
  logic                sm_fetch;
  logic                sm_mode;
  logic                sm_reset;
  logic                res_valid;
  logic                res_last;
  logic                busy;
  logic                done;

  modport slave (
    input  cmd_valid, cmd_op, abort, src_valid, src_data,
    output cmd_ready, src_ready, sm_in, sm_lut_wr, sm_execute, sm_fetch,
           sm_mode, sm_reset, res_valid, res_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, abort, src_valid, src_data,
    input  cmd_ready, src_ready, sm_in, sm_lut_wr, sm_execute, sm_fetch,
           sm_mode, sm_reset, res_valid, res_last, busy, done
  );
endinterface

// File: rtl/softmax_ctrl.sv
// Command sequencer for a non-stallable softmax core: buffers source rows, then
// replays them onto the core pins with fixed LUT-write, 8-input and 8x8 timelines.
module softmax_ctrl #(
  parameter int BW        = 8,
  parameter int COL       = 8,
  parameter int ROWS      = 8,
  parameter int LUT_WAIT  = 9,
  parameter int EXEC0_CYC = 10,
  parameter int FETCH_PER = 5
) (
  input  logic          clk,
  input  logic          reset,
  softmax_ctrl_if.slave bus
);
  localparam int DW        = COL * BW;
  localparam int PW        = $clog2(ROWS) + 1;
  localparam int CMAX      = ROWS * FETCH_PER + ROWS + EXEC0_CYC + LUT_WAIT + 8;
  localparam int CW        = $clog2(CMAX) + 1;
  localparam int PHW       = $clog2(FETCH_PER) + 1;
  localparam int DRAIN_CYC = 5;

  typedef enum logic [3:0] {
    IDLE, LOAD, LUT_WR, LUT_HOLD, R8_EXEC, R64_KICK, R64_FEED,
    R64_DRAIN, R64_FETCH, DONE, ABORT
  } state_e;

  typedef enum logic [1:0] {
    OP_LUT_LSB = 2'b00,
    OP_LUT_MSB = 2'b01,
    OP_RUN8    = 2'b10,
    OP_RUN64   = 2'b11
  } op_e;

  state_e          state, state_d;
  op_e             op, op_d;
  logic            mode, mode_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [PHW-1:0]  ph, ph_d;
  logic [PW-1:0]   wr_ptr, wr_d, rd_ptr, rd_d;
  logic [PW-1:0]   last_row;
  logic            row_take;
  logic [DW-1:0]   row_buf [ROWS];

  assign last_row    = (op == OP_RUN64) ? PW'(ROWS - 1) : '0;
  assign bus.sm_mode = mode;
  assign bus.busy    = (state != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d        = state;
    op_d           = op;
    mode_d         = mode;
    cnt_d          = cnt + 1'b1;
    ph_d           = ph;
    wr_d           = wr_ptr;
    rd_d           = rd_ptr;
    row_take       = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.src_ready  = 1'b0;
    bus.sm_in      = '0;
    bus.sm_lut_wr  = 2'b00;
    bus.sm_execute = 1'b0;
    bus.sm_fetch   = 1'b0;
    bus.sm_reset   = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_last   = 1'b0;
    bus.done       = 1'b0;

    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        cnt_d         = '0;
        if (bus.cmd_valid && bus.abort) begin
          state_d = ABORT;
        end else if (bus.cmd_valid) begin
          op_d = op_e'(bus.cmd_op);
          if (bus.cmd_op[1]) mode_d = bus.cmd_op[0];
          state_d = LOAD;
        end
      end
      LOAD: begin
        // An abort withdraws ready so the source never sees a row as consumed.
        bus.src_ready = ~bus.abort;
        row_take      = bus.src_valid & ~bus.abort;
        cnt_d         = '0;
        if (row_take) begin
          wr_d = wr_ptr + 1'b1;
          if (wr_ptr == last_row) begin
            case (op)
              OP_RUN8:  state_d = R8_EXEC;
              OP_RUN64: state_d = R64_KICK;
              default:  state_d = LUT_WR;
            endcase
          end
        end
      end
      LUT_WR: begin
        bus.sm_in     = row_buf[0];
        bus.sm_lut_wr = (op == OP_LUT_MSB) ? 2'b10 : 2'b01;
        cnt_d         = '0;
        state_d       = LUT_HOLD;
      end
      LUT_HOLD: begin
        bus.sm_in = row_buf[0];
        if (cnt == CW'(LUT_WAIT - 1)) state_d = DONE;
      end
      R8_EXEC: begin
        bus.sm_in = row_buf[0];
        if (cnt < CW'(EXEC0_CYC)) begin
          bus.sm_execute = 1'b1;
        end else begin
          bus.res_valid = 1'b1;
          bus.res_last  = 1'b1;
          state_d       = DONE;
        end
      end
      R64_KICK: begin
        bus.sm_execute = (cnt == '0);
        if (cnt == CW'(1)) state_d = R64_FEED;
      end
      R64_FEED: begin
        bus.sm_in = row_buf[rd_ptr[PW-2:0]];
        rd_d      = rd_ptr + 1'b1;
        if (rd_ptr == PW'(ROWS - 1)) state_d = R64_DRAIN;
      end
      R64_DRAIN: begin
        if (cnt == CW'(2 + ROWS + DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          ph_d    = '0;
          state_d = R64_FETCH;
        end
      end
      R64_FETCH: begin
        bus.sm_fetch = 1'b1;
        if (ph == PHW'(FETCH_PER - 1)) begin
          bus.res_valid = 1'b1;
          ph_d          = '0;
          if (cnt == CW'(ROWS * FETCH_PER - 1)) begin
            bus.res_last = 1'b1;
            state_d      = DONE;
          end
        end else begin
          ph_d = ph + 1'b1;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        wr_d     = '0;
        rd_d     = '0;
        state_d  = IDLE;
      end
      ABORT: begin
        bus.sm_reset = 1'b1;
        if (cnt == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && state != IDLE) begin
      state_d = ABORT;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op     <= OP_LUT_LSB;
      mode   <= 1'b0;
      cnt    <= '0;
      ph     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_d;
      op     <= op_d;
      mode   <= mode_d;
      cnt    <= cnt_d;
      ph     <= ph_d;
      wr_ptr <= wr_d;
      rd_ptr <= rd_d;
    end
  end

  // NOTE: the row buffer is not reset; rows are always written before they are read.
  always_ff @(posedge clk) begin
    if (row_take) row_buf[wr_ptr[PW-2:0]] <= bus.src_data;
  end
endmodule

// File: tb/tb_softmax_ctrl.sv
// Scoreboard bench for softmax_ctrl: stimulus queues expected core-pin events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_softmax_ctrl;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  softmax_ctrl_if bus ();
  softmax_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {EV_LUT, EV_EXEC, EV_ROW, EV_FETCH, EV_RES, EV_RST, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [71:0] value;
    int          dt;
  } ev_t;

  ev_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [71:0] v, input int dt);
    ev_t e;
    e.kind  = k;
    e.value = v;
    e.dt    = dt;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0, anchor = 0, exec_len = 0, fetch_len = 0, rst_len = 0;
  logic       p_exec = 1'b0, p_fetch = 1'b0, p_rst = 1'b0;
  logic [1:0] p_lut = 2'b00;

  task automatic observe(input ev_kind_e k, input logic [71:0] v, input int dt);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected %s event: value %0h dt %0d, none required", k.name(), v, dt);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k || e.value !== v || e.dt != dt) begin
      miscompares++;
      $display("FAIL event: got %s value %0h dt %0d, required %s value %0h dt %0d",
               k.name(), v, dt, e.kind.name(), e.value, e.dt);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      p_exec = 1'b0; p_fetch = 1'b0; p_rst = 1'b0; p_lut = 2'b00;
    end else begin
      if (bus.sm_lut_wr != 2'b00 && p_lut == 2'b00) anchor = cyc;
      if (bus.sm_execute && !p_exec) begin anchor = cyc; exec_len = 0; end
      if (bus.sm_fetch && !p_fetch) fetch_len = 0;
      if (bus.sm_reset && !p_rst) rst_len = 0;
      if (bus.sm_execute) exec_len++;
      if (bus.sm_fetch) fetch_len++;
      if (bus.sm_reset) rst_len++;

      if (bus.sm_lut_wr != 2'b00) observe(EV_LUT, {6'd0, bus.sm_lut_wr, bus.sm_in}, cyc - anchor);
      if (!bus.sm_execute && p_exec) observe(EV_EXEC, 72'(exec_len), cyc - anchor);
      if (bus.sm_mode && bus.busy && !bus.sm_fetch && bus.sm_in != '0)
        observe(EV_ROW, {8'd0, bus.sm_in}, cyc - anchor);
      if (!bus.sm_fetch && p_fetch) observe(EV_FETCH, 72'(fetch_len), cyc - anchor);
      if (bus.res_valid) observe(EV_RES, {71'd0, bus.res_last}, cyc - anchor);
      if (!bus.sm_reset && p_rst) observe(EV_RST, 72'(rst_len), cyc - anchor);
      if (bus.done) observe(EV_DONE, 72'd1, cyc - anchor);

      p_exec = bus.sm_execute; p_fetch = bus.sm_fetch;
      p_rst  = bus.sm_reset;   p_lut   = bus.sm_lut_wr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    bit taken;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk) taken = bus.cmd_ready;
      tick();
      if (taken) begin
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    bus.cmd_valid = 1'b0;
    vectors++; miscompares++;
    $display("FAIL cmd_timeout: cmd_ready got 0 for 50 cycles, required 1");
  endtask

  task automatic send_row(input logic [63:0] d);
    bit taken;
    bus.src_valid = 1'b1;
    bus.src_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk) taken = bus.src_ready;
      tick();
      if (taken) begin
        bus.src_valid = 1'b0;
        return;
      end
    end
    bus.src_valid = 1'b0;
    vectors++; miscompares++;
    $display("FAIL row_timeout: src_ready got 0 for 50 cycles, required 1");
  endtask

  task automatic wait_for(input int which, input string name);
    logic hit;
    for (int i = 0; i < 200; i++) begin
      case (which)
        0:       hit = bus.sm_execute;
        1:       hit = bus.sm_fetch;
        default: hit = bus.done;
      endcase
      if (hit) return;
      tick();
    end
    vectors++; miscompares++;
    $display("FAIL %s: got 0 for 200 cycles, required 1", name);
  endtask

  function automatic logic [63:0] row64(input int k);
    logic [7:0] b;
    b = 8'((k + 1) * 17);
    return {8{b}};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_core_pins"}, {bus.sm_lut_wr, bus.sm_execute, bus.sm_fetch, bus.sm_mode, bus.sm_reset}, 0);
    check({tag, "_sm_in"}, bus.sm_in, 0);
    check({tag, "_flags"}, {bus.src_ready, bus.res_valid, bus.res_last, bus.busy, bus.done}, 0);
  endtask

  initial begin
    logic [63:0] lut_row, r8_row, lsb_row;
    lut_row = 64'h0706050403020100;
    r8_row  = {8{8'h10}};
    lsb_row = 64'hA5A5_5A5A_C3C3_3C3C;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.abort = 1'b0;
    bus.src_valid = 1'b0; bus.src_data = '0;

    #1 check_idle_outputs("reset");
    tick(); tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // LUT_MSB: one write pulse carrying the row, done 10 cycles later
    expect_ev(EV_LUT, {6'd0, 2'b10, lut_row}, 0);
    expect_ev(EV_DONE, 72'd1, 10);
    send_cmd(2'b01);
    check("lut_load_no_core", {bus.sm_lut_wr, bus.sm_execute}, 0);
    send_row(lut_row);
    check("lut_wr_pulse", bus.sm_lut_wr, 2'b10);
    tick();
    check("lut_hold_in", bus.sm_in, lut_row);
    check("lut_hold_src_ready", bus.src_ready, 0);
    wait_for(2, "lut_msb_done");
    tick();

    // RUN8 with the source stalled for 3 cycles
    expect_ev(EV_EXEC, 72'd10, 10);
    expect_ev(EV_RES, 72'd1, 10);
    expect_ev(EV_DONE, 72'd1, 11);
    send_cmd(2'b10);
    for (int i = 0; i < 3; i++) begin
      check("r8_stall_no_exec", {bus.sm_execute, bus.src_ready}, 2'b01);
      tick();
    end
    send_row(r8_row);
    check("r8_exec_in", {bus.sm_execute, bus.sm_mode, bus.sm_in}, {2'b10, r8_row});
    wait_for(2, "r8_done");
    tick();

    // RUN64 full pass with toggling src_valid
    expect_ev(EV_EXEC, 72'd1, 1);
    for (int k = 0; k < 8; k++) expect_ev(EV_ROW, {8'd0, row64(k)}, 2 + k);
    for (int k = 0; k < 8; k++) expect_ev(EV_RES, (k == 7) ? 72'd1 : 72'd0, 19 + 5 * k);
    expect_ev(EV_FETCH, 72'd40, 55);
    expect_ev(EV_DONE, 72'd1, 55);
    send_cmd(2'b11);
    for (int k = 0; k < 8; k++) begin
      send_row(row64(k));
      if (k != 7) tick();
    end
    check("r64_kick", {bus.sm_execute, bus.sm_mode}, 2'b11);
    wait_for(2, "r64_done");
    tick();

    // RUN64 aborted at X5
    expect_ev(EV_EXEC, 72'd1, 1);
    for (int k = 0; k < 4; k++) expect_ev(EV_ROW, {8'd0, row64(k)}, 2 + k);
    expect_ev(EV_RST, 72'd2, 8);
    send_cmd(2'b11);
    for (int k = 0; k < 8; k++) send_row(row64(k));
    repeat (5) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_x6", {bus.sm_execute, bus.sm_fetch, bus.sm_lut_wr, bus.sm_reset, bus.done}, 6'b000010);
    tick();
    check("abort_x7", {bus.sm_reset, bus.cmd_ready}, 2'b10);
    tick();
    check("abort_x8", {bus.sm_reset, bus.cmd_ready, bus.busy}, 3'b010);

    // Async reset in the middle of R64_FETCH
    expect_ev(EV_EXEC, 72'd1, 1);
    for (int k = 0; k < 8; k++) expect_ev(EV_ROW, {8'd0, row64(7 - k)}, 2 + k);
    send_cmd(2'b11);
    for (int k = 0; k < 8; k++) send_row(row64(7 - k));
    wait_for(1, "r64_fetch_start");
    tick(); tick();
    #2 reset = 1'b1;
    #1 check_idle_outputs("async_reset");
    tick();
    reset = 1'b0;
    tick();

    // LUT_LSB after reset completes normally
    expect_ev(EV_LUT, {6'd0, 2'b01, lsb_row}, 0);
    expect_ev(EV_DONE, 72'd1, 10);
    send_cmd(2'b00);
    send_row(lsb_row);
    wait_for(2, "lut_lsb_done");
    tick();

    // cmd_valid held across a RUN8; the queued LUT_LSB is taken right after done
    expect_ev(EV_EXEC, 72'd10, 10);
    expect_ev(EV_RES, 72'd1, 10);
    expect_ev(EV_DONE, 72'd1, 11);
    expect_ev(EV_LUT, {6'd0, 2'b01, r8_row ^ lsb_row}, 0);
    expect_ev(EV_DONE, 72'd1, 10);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    tick();
    bus.cmd_op = 2'b00;
    check("held_load_ready", bus.cmd_ready, 0);
    send_row(r8_row);
    check("held_exec_ready", {bus.cmd_ready, bus.busy}, 2'b01);
    wait_for(2, "held_r8_done");
    check("held_done_ready", bus.cmd_ready, 0);
    tick();
    check("held_idle_ready", {bus.cmd_ready, bus.busy}, 2'b10);
    tick();
    check("held_second_accept", {bus.cmd_ready, bus.busy}, 2'b01);
    bus.cmd_valid = 1'b0;
    send_row(r8_row ^ lsb_row);
    wait_for(2, "held_lut_done");
    repeat (5) tick();

    check("scoreboard_drained", 72'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end
endmodule
